cordic_iter_ctrl: RTL and testbench

- Sequencer that time-multiplexes one registered CORDIC iterator stage over ITER micro-rotations per operand.
- Accepts one operand (z, x, y, quadrant) through a valid/ready handshake and feeds the iterator with shift index i = 0..ITER-1.
- Feeds the iterator's registered outputs back for each later iteration, then latches the final result into output registers presented through a valid/ready handshake.
- Sits between the upstream pre-rotation logic and the downstream post-scaling/quadrant-correction logic.

---
 rtl/cordic_iter_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: time-multiplexes one external, registered CORDIC iterator
// stage over ITER micro-rotations per operand.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_z, in_x, in_y, in_quadrant)
//   out_valid/out_ready result handshake (out_z, out_x, out_y, out_quadrant)
//   it_z/x/y/quadrant   iterator stage inputs, it_i = shift index
//   it_*_o              iterator stage registered outputs (fed back)
//   busy                high while iterating or latching the result
//
// The iterator registers one micro-rotation every clock. Iteration 0 is fed
// from the hold registers, later iterations from the iterator's own outputs.
// After the last iteration one LATCH cycle copies the iterator outputs into
// the output registers, which are held in OUT until downstream accepts.

module cordic_iter_ctrl #(
  parameter int unsigned ITER = 20,
  parameter int unsigned ZW   = 25,
  parameter int unsigned XW   = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [ZW-1:0] in_z,
  input  logic signed [XW-1:0] in_x,
  input  logic signed [XW-1:0] in_y,
  input  logic        [2:0]    in_quadrant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [ZW-1:0] out_z,
  output logic signed [XW-1:0] out_x,
  output logic signed [XW-1:0] out_y,
  output logic        [2:0]    out_quadrant,
  output logic signed [ZW-1:0] it_z,
  output logic signed [XW-1:0] it_x,
  output logic signed [XW-1:0] it_y,
  output logic        [2:0]    it_quadrant,
  output logic        [5:0]    it_i,
  input  logic signed [ZW-1:0] it_z_o,
  input  logic signed [XW-1:0] it_x_o,
  input  logic signed [XW-1:0] it_y_o,
  input  logic        [2:0]    it_quadrant_o,
  output logic                 busy
);

  localparam int unsigned CW = 6;
  localparam int unsigned QW = 3;
  localparam logic [CW-1:0] LAST_IT = CW'(ITER - 1);

  // Reject illegal iteration counts at elaboration.
  if (ITER < 1 || ITER > 63) begin : g_bad_iter
    $error("cordic_iter_ctrl: ITER must be in 1..63");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LATCH = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rdy_en_q;
  logic signed [ZW-1:0]  hold_z_q, hold_z_d;
  logic signed [XW-1:0]  hold_x_q, hold_x_d;
  logic signed [XW-1:0]  hold_y_q, hold_y_d;
  logic        [QW-1:0]  hold_q_q, hold_q_d;
  logic signed [ZW-1:0]  out_z_q, out_z_d;
  logic signed [XW-1:0]  out_x_q, out_x_d;
  logic signed [XW-1:0]  out_y_q, out_y_d;
  logic        [QW-1:0]  out_q_q, out_q_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  feedback;

  // Ready is held low until the first clock edge after reset release.
  assign in_ready = rdy_en_q & ((state_q == S_IDLE) |
                                ((state_q == S_OUT) & out_ready));
  assign accept   = in_valid & in_ready;

  // Iterations after the first take the iterator's own registered results.
  assign feedback    = (state_q == S_RUN) && (cnt_q != '0);
  assign it_z        = feedback ? it_z_o        : hold_z_q;
  assign it_x        = feedback ? it_x_o        : hold_x_q;
  assign it_y        = feedback ? it_y_o        : hold_y_q;
  assign it_quadrant = feedback ? it_quadrant_o : hold_q_q;
  assign it_i        = (state_q == S_RUN) ? cnt_q : '0;

  assign out_z        = out_z_q;
  assign out_x        = out_x_q;
  assign out_y        = out_y_q;
  assign out_quadrant = out_q_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;

  // Next-state, counter, capture and output-register logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_z_d = hold_z_q;
    hold_x_d = hold_x_q;
    hold_y_d = hold_y_q;
    hold_q_d = hold_q_q;
    out_z_d  = out_z_q;
    out_x_d  = out_x_q;
    out_y_d  = out_y_q;
    out_q_d  = out_q_q;

    // Accept is only possible in IDLE or in OUT while the result is taken.
    if (accept) begin
      hold_z_d = in_z;
      hold_x_d = in_x;
      hold_y_d = in_y;
      hold_q_d = in_quadrant;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_IT) begin
          cnt_d   = '0;
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        out_z_d = it_z_o;
        out_x_d = it_x_o;
        out_y_d = it_y_o;
        out_q_d = it_quadrant_o;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (in_valid) begin
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d == S_RUN) || (state_d == S_LATCH);
  end

  // State and data registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
      hold_z_q    <= '0;
      hold_x_q    <= '0;
      hold_y_q    <= '0;
      hold_q_q    <= '0;
      out_z_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdy_en_q    <= 1'b1;
      hold_z_q    <= hold_z_d;
      hold_x_q    <= hold_x_d;
      hold_y_q    <= hold_y_d;
      hold_q_q    <= hold_q_d;
      out_z_q     <= out_z_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_q_q     <= out_q_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Testbench for cordic_iter_ctrl: three instances (ITER = 4, 20, 1), each
// paired with a behavioural registered CORDIC micro-rotation stage. Expected
// results come from chaining the micro-rotation in a plain loop.
module tb_cordic_iter_ctrl;

  localparam int unsigned ZW = 25;
  localparam int unsigned XW = 30;
  localparam int unsigned NI = 3;

  typedef struct packed {
    logic signed [ZW-1:0] z;
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;
    logic        [2:0]    q;
  } rot_t;

  typedef struct {
    rot_t op;
    rot_t exp;
    int   stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic          in_valid  [NI];
  logic          in_ready  [NI];
  logic          out_valid [NI];
  logic          out_ready [NI];
  logic          busy      [NI];
  logic [ZW-1:0] out_z [NI], itz [NI], itz_o [NI];
  logic [XW-1:0] out_x [NI], itx [NI], itx_o [NI];
  logic [XW-1:0] out_y [NI], ity [NI], ity_o [NI];
  logic [2:0]    out_q [NI], itq [NI], itq_o [NI];
  logic [5:0]    it_i  [NI];
  logic [ZW-1:0] in_z;
  logic [XW-1:0] in_x, in_y;
  logic [2:0]    in_q;

  // atan(2^-i) in units of 2^-20 rad
  function automatic int atan_u(input int i);
    return $rtoi($atan(1.0 / (2.0 ** i)) * 1048576.0 + 0.5);
  endfunction

  // One rotation-mode micro-rotation, as the external iterator performs it.
  function automatic rot_t micro(input rot_t a, input int i);
    rot_t r;
    int t;
    t = atan_u(i);
    r.q = a.q;
    if (a.z >= 0) begin
      r.x = a.x - (a.y >>> i);
      r.y = a.y + (a.x >>> i);
      r.z = ZW'(a.z - t);
    end else begin
      r.x = a.x + (a.y >>> i);
      r.y = a.y - (a.x >>> i);
      r.z = ZW'(a.z + t);
    end
    return r;
  endfunction

  // Reference: n chained micro-rotations on the operand.
  function automatic rot_t ref_run(input rot_t a, input int n);
    rot_t r;
    r = a;
    for (int i = 0; i < n; i++) r = micro(r, i);
    return r;
  endfunction

  function automatic int iters_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 20 : 1);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned IT = (g == 0) ? 4 : ((g == 1) ? 20 : 1);
    cordic_iter_ctrl #(.ITER(IT), .ZW(ZW), .XW(XW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_z(in_z), .in_x(in_x), .in_y(in_y), .in_quadrant(in_q),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_z(out_z[g]), .out_x(out_x[g]), .out_y(out_y[g]),
      .out_quadrant(out_q[g]),
      .it_z(itz[g]), .it_x(itx[g]), .it_y(ity[g]), .it_quadrant(itq[g]),
      .it_i(it_i[g]),
      .it_z_o(itz_o[g]), .it_x_o(itx_o[g]), .it_y_o(ity_o[g]),
      .it_quadrant_o(itq_o[g]),
      .busy(busy[g])
    );
    // external iterator: registers one micro-rotation every clock
    always_ff @(posedge clk) begin
      {itz_o[g], itx_o[g], ity_o[g], itq_o[g]} <=
        micro(rot_t'({itz[g], itx[g], ity[g], itq[g]}), int'(it_i[g]));
    end
  end

  function automatic rot_t dut_out(input int g);
    return rot_t'({out_z[g], out_x[g], out_y[g], out_q[g]});
  endfunction
  function automatic rot_t it_in(input int g);
    return rot_t'({itz[g], itx[g], ity[g], itq[g]});
  endfunction
  function automatic rot_t it_out(input int g);
    return rot_t'({itz_o[g], itx_o[g], ity_o[g], itq_o[g]});
  endfunction
  function automatic rot_t rand_op();
    rot_t r;
    r.z = ZW'($urandom);
    r.x = XW'($urandom);
    r.y = XW'($urandom);
    r.q = 3'($urandom);
    return r;
  endfunction

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rot(input string nm, input rot_t act, input rot_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input rot_t op);
    in_z = op.z; in_x = op.x; in_y = op.y; in_q = op.q;
  endtask

  // Called right after the accept edge: follows the run, checks the result,
  // then holds it with out_ready low for 'stall' cycles.
  task automatic collect(input int g, input rot_t op, input rot_t exp_r,
                         input int stall);
    int it, k, bad;
    rot_t fb;
    it = iters_of(g);
    k = 0;
    bad = 0;
    while (!out_valid[g] && k < it + 20) begin
      if (k < it) begin
        if (int'(it_i[g]) != k) bad++;
        fb = (k == 0) ? op : it_out(g);
        if (it_in(g) !== fb) bad++;
      end
      if (busy[g] != (k <= it)) bad++;
      if (in_ready[g]) bad++;
      tick();
      k++;
    end
    chk_int("latency_edges", k, it + 1);
    chk_int("run_sequence", bad, 0);
    chk_rot("result", dut_out(g), exp_r);
    chk_int("out_hold_ready", int'(in_ready[g]), 0);
    bad = 0;
    for (int s = 0; s < stall; s++) begin
      tick();
      if (dut_out(g) !== exp_r || !out_valid[g] || in_ready[g] || busy[g]) bad++;
    end
    if (stall > 0) chk_int("stall_hold", bad, 0);
  endtask

  task automatic consume(input int g);
    out_ready[g] = 1'b1;
    tick();
    out_ready[g] = 1'b0;
    chk_int("consumed_vbr", int'({out_valid[g], busy[g], in_ready[g]}), 1);
  endtask

  task automatic do_op(input int g, input rot_t op, input rot_t exp_r,
                       input int stall);
    int k;
    set_in(op);
    in_valid[g] = 1'b1;
    k = 0;
    while (!in_ready[g] && k < 50) begin tick(); k++; end
    chk_int("accept_ready", int'(in_ready[g]), 1);
    tick();
    in_valid[g] = 1'b0;
    collect(g, op, exp_r, stall);
    consume(g);
  endtask

  task automatic back_to_back(input int g);
    int it, e, ia, ic, guard;
    bit acc_now, cons_now;
    rot_t ops [3];
    rot_t exps [3];
    int acc_e [$];
    int cons_e [$];
    it = iters_of(g);
    e = 0; ia = 0; ic = 0; guard = 0;
    for (int i = 0; i < 3; i++) begin
      ops[i]  = rand_op();
      exps[i] = ref_run(ops[i], it);
    end
    set_in(ops[0]);
    in_valid[g]  = 1'b1;
    out_ready[g] = 1'b1;
    while (ic < 3 && guard < 200) begin
      acc_now  = in_valid[g] && in_ready[g];
      cons_now = out_valid[g] && out_ready[g];
      if (cons_now) chk_rot("b2b_result", dut_out(g), exps[ic]);
      tick();
      e++; guard++;
      if (acc_now) begin
        acc_e.push_back(e);
        ia++;
        if (ia < 3) set_in(ops[ia]);
        else in_valid[g] = 1'b0;
      end
      if (cons_now) begin
        cons_e.push_back(e);
        ic++;
      end
    end
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b0;
    chk_int("b2b_results", ic, 3);
    chk_int("b2b_accepts", acc_e.size(), 3);
    if (acc_e.size() == 3 && cons_e.size() == 3) begin
      for (int i = 0; i < 2; i++) begin
        chk_int("b2b_spacing", acc_e[i+1] - acc_e[i], it + 2);
        chk_int("b2b_coincide", cons_e[i], acc_e[i+1]);
      end
      chk_int("b2b_last_lat", cons_e[2] - acc_e[2], it + 2);
    end
  endtask

  // Operand offered during RUN must wait for the result hand-off.
  task automatic offer_while_busy(input int g);
    rot_t a, b;
    int k;
    a = rand_op();
    b = rand_op();
    set_in(a);
    in_valid[g] = 1'b1;
    k = 0;
    while (!in_ready[g] && k < 50) begin tick(); k++; end
    tick();
    set_in(b);
    collect(g, a, ref_run(a, iters_of(g)), 3);
    out_ready[g] = 1'b1;
    #1;
    chk_int("ready_on_handoff", int'(in_ready[g]), 1);
    tick();
    out_ready[g] = 1'b0;
    in_valid[g]  = 1'b0;
    collect(g, b, ref_run(b, iters_of(g)), 0);
    consume(g);
  endtask

  task automatic reset_mid_run();
    rot_t a;
    int k, bad;
    a = rand_op();
    set_in(a);
    in_valid[1] = 1'b1;
    k = 0;
    while (!in_ready[1] && k < 50) begin tick(); k++; end
    tick();
    in_valid[1] = 1'b0;
    k = 0;
    while (int'(it_i[1]) != 7 && k < 40) begin tick(); k++; end
    chk_int("reach_cnt7", int'(it_i[1]), 7);
    #2 rst_n = 1'b0;
    #1;
    chk_int("rst_async_vbr", int'({out_valid[1], busy[1], in_ready[1]}), 0);
    chk_int("rst_async_it_i", int'(it_i[1]), 0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_int("ready_after_rst", int'(in_ready[1]), 1);
    bad = 0;
    for (int s = 0; s < 30; s++) begin
      if (out_valid[1] || busy[1]) bad++;
      tick();
    end
    chk_int("no_stale_result", bad, 0);
    a = rand_op();
    do_op(1, a, ref_run(a, 20), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    rot_t op;
    int   zz;

    for (int g = 0; g < int'(NI); g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b0;
    end
    set_in(rot_t'(0));

    // vector table for the ITER=4 instance
    vecs[0].op = rot_t'({ZW'(1000), XW'(1 << 20), XW'(0), 3'd5});
    vecs[0].stall = 0;
    vecs[1].op = rot_t'({ZW'(-5000), XW'(1 << 20), XW'(0), 3'd2});
    vecs[1].stall = 10;
    vecs[2].op = rot_t'({ZW'(0), XW'(-(1 << 25)), XW'(12345), 3'd7});
    vecs[2].stall = 1;
    for (int i = 3; i < 10; i++) begin
      vecs[i].op    = rand_op();
      vecs[i].stall = int'($urandom_range(0, 4));
    end
    for (int i = 0; i < 10; i++) vecs[i].exp = ref_run(vecs[i].op, 4);

    #1;
    for (int g = 0; g < int'(NI); g++) begin
      chk_int("rst_vbr", int'({out_valid[g], busy[g], in_ready[g]}), 0);
      chk_rot("rst_out", dut_out(g), rot_t'(0));
      chk_int("rst_it_i", int'(it_i[g]), 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int g = 0; g < int'(NI); g++)
      chk_int("idle_ready", int'(in_ready[g]), 1);

    for (int i = 0; i < 10; i++) do_op(0, vecs[i].op, vecs[i].exp, vecs[i].stall);
    chk_int("quadrant_passthru", int'(ref_run(vecs[0].op, 4).q), 5);

    // ITER=20 convergence with negative starting angle
    op = rot_t'({ZW'(-5000), XW'(1 << 20), XW'(0), 3'd3});
    do_op(1, op, ref_run(op, 20), 0);
    zz = int'($signed(out_z[1]));
    if (zz < 0) zz = -zz;
    n_checks++;
    if (zz > atan_u(19)) begin
      n_fail++;
      $display("FAIL z_converge: |z| got %0d limit %0d", zz, atan_u(19));
    end

    // ITER=1 instance with random operands and stalls
    for (int i = 0; i < 6; i++) begin
      op = rand_op();
      do_op(2, op, ref_run(op, 1), int'($urandom_range(0, 3)));
    end

    back_to_back(0);
    back_to_back(2);
    offer_while_busy(0);
    reset_mid_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
